gshare_bp: RTL and testbench

Parametrised gshare branch predictor with an integrated branch target buffer, the successor to the fixed 7-bit GHR/PHT/BTB predictor. It sits beside the fetch PC generator: fetch issues a lookup per cycle and receives a registered direction, hit and next-PC one cycle later. The execute stage returns resolved branches on a separate update port that trains the pattern history table (PHT) and BTB and repairs the global history register (GHR).

---
 rtl/gshare_bp.sv | 130 +++++++++++++
 tb/tb_gshare_bp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_bp.sv
// rtl/gshare_bp.sv - gshare direction predictor with BTB; GSHARE_SPEC_GHR_EN selects speculative GHR update
module gshare_bp #(
    parameter int         ADDR_W    = 32,
    parameter int         HIST_W    = 7,
    parameter int         BTB_IDX_W = 7,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_req,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              pred_vld,
    output logic              pred_taken,
    output logic              pred_hit,
    output logic [ADDR_W-1:0] pred_target,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_vld,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispred,
    output logic [15:0]       mispred_cnt
);
    localparam int TAG_W = ADDR_W - 2 - BTB_IDX_W;
    localparam int PHT_N = 1 << HIST_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [HIST_W-1:0] ghr;
    logic [1:0]        pht        [PHT_N];
    logic              btb_valid  [BTB_N];
    logic [TAG_W-1:0]  btb_tag    [BTB_N];
    logic [ADDR_W-1:0] btb_target [BTB_N];

    logic [HIST_W-1:0]    look_pht_idx;
    logic [BTB_IDX_W-1:0] look_btb_idx;
    logic                 look_taken;
    logic                 look_hit;
    logic [ADDR_W-1:0]    look_target;
    logic [HIST_W-1:0]    upd_pht_idx;
    logic [BTB_IDX_W-1:0] upd_btb_idx;
    logic                 unused_align;

    // Word alignment makes the low PC bits meaningless for both structures.
    assign unused_align = ^{pred_pc[1:0], upd_pc[1:0]};

    assign look_pht_idx = pred_pc[HIST_W+1:2] ^ ghr;
    assign look_btb_idx = pred_pc[BTB_IDX_W+1:2];
    assign look_taken   = pht[look_pht_idx][1];
    assign look_hit     = btb_valid[look_btb_idx] &&
                          (btb_tag[look_btb_idx] == pred_pc[ADDR_W-1:BTB_IDX_W+2]);
    assign look_target  = (look_taken && look_hit) ? btb_target[look_btb_idx]
                                                   : pred_pc + ADDR_W'(4);

    assign upd_pht_idx = upd_pc[HIST_W+1:2] ^ upd_ghr;
    assign upd_btb_idx = upd_pc[BTB_IDX_W+1:2];

    // Lookup results are registered; a lookup colliding with an update sees old contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_vld    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_target <= '0;
            pred_ghr    <= '0;
        end else begin
            pred_vld <= pred_req;
            if (pred_req) begin
                pred_taken  <= look_taken;
                pred_hit    <= look_hit;
                pred_target <= look_target;
                pred_ghr    <= ghr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else begin
`ifdef GSHARE_SPEC_GHR_EN
            // Repair from execute overrides the speculative shift of the same cycle.
            if (upd_vld && upd_mispred)
                ghr <= {upd_ghr[HIST_W-2:0], upd_taken};
            else if (pred_req)
                ghr <= {ghr[HIST_W-2:0], look_taken};
`else
            if (upd_vld)
                ghr <= {ghr[HIST_W-2:0], upd_taken};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht[i] <= CTR_INIT;
        end else if (upd_vld) begin
            if (upd_taken && (pht[upd_pht_idx] != 2'b11))
                pht[upd_pht_idx] <= pht[upd_pht_idx] + 2'd1;
            else if (!upd_taken && (pht[upd_pht_idx] != 2'b00))
                pht[upd_pht_idx] <= pht[upd_pht_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_N; i++)
                btb_valid[i] <= 1'b0;
        end else if (upd_vld && upd_taken) begin
            btb_valid[upd_btb_idx] <= 1'b1;
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_vld && upd_taken) begin
            btb_tag[upd_btb_idx]    <= upd_pc[ADDR_W-1:BTB_IDX_W+2];
            btb_target[upd_btb_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mispred_cnt <= '0;
        else if (upd_vld && upd_mispred && (mispred_cnt != 16'hFFFF))
            mispred_cnt <= mispred_cnt + 16'd1;
    end

endmodule

// File: tb/tb_gshare_bp.sv
// tb/tb_gshare_bp.sv - scoreboard bench for gshare_bp (GSHARE_SPEC_GHR_EN selects the scenario set)
module tb_gshare_bp;
    logic        clk;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_vld;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic [6:0]  pred_ghr;
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic [6:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [15:0] mispred_cnt;

    gshare_bp #(.ADDR_W(32), .HIST_W(7), .BTB_IDX_W(7), .CTR_INIT(2'b01)) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_vld(pred_vld), .pred_taken(pred_taken), .pred_hit(pred_hit),
        .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .mispred_cnt(mispred_cnt)
    );

    typedef struct {
        int          due;
        logic        taken;
        logic        hit;
        logic [31:0] target;
        logic [6:0]  ghr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic mon_vld;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each lookup pushes its expected result, due one edge later.
    always @(negedge clk) begin
        if (rst) begin
            mon_vld = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (pred_vld !== mon_vld) begin
                errors++;
                $display("FAIL pred_vld at cyc %0d: got %b want %b", cyc, pred_vld, mon_vld);
            end
            if (mon_vld) begin
                mon_e = q.pop_front();
                checks += 4;
                if (pred_taken !== mon_e.taken) begin
                    errors++;
                    $display("FAIL pred_taken at cyc %0d: got %b want %b", cyc, pred_taken, mon_e.taken);
                end
                if (pred_hit !== mon_e.hit) begin
                    errors++;
                    $display("FAIL pred_hit at cyc %0d: got %b want %b", cyc, pred_hit, mon_e.hit);
                end
                if (pred_target !== mon_e.target) begin
                    errors++;
                    $display("FAIL pred_target at cyc %0d: got %h want %h", cyc, pred_target, mon_e.target);
                end
                if (pred_ghr !== mon_e.ghr) begin
                    errors++;
                    $display("FAIL pred_ghr at cyc %0d: got %h want %h", cyc, pred_ghr, mon_e.ghr);
                end
            end
        end
    end

    task automatic push_exp(input logic t, input logic h, input logic [31:0] tgt, input logic [6:0] g);
        exp_t e;
        e.due = cyc + 1;
        e.taken = t;
        e.hit = h;
        e.target = tgt;
        e.ghr = g;
        q.push_back(e);
    endtask

    task automatic look(input logic [31:0] pc, input logic t, input logic h,
                        input logic [31:0] tgt, input logic [6:0] g);
        pred_req = 1'b1;
        pred_pc  = pc;
        push_exp(t, h, tgt, g);
        @(negedge clk);
        pred_req = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [6:0] g, input logic t,
                       input logic [31:0] tgt, input logic mis);
        upd_vld     = 1'b1;
        upd_pc      = pc;
        upd_ghr     = g;
        upd_taken   = t;
        upd_target  = tgt;
        upd_mispred = mis;
        @(negedge clk);
        upd_vld     = 1'b0;
        upd_mispred = 1'b0;
    endtask

    // Seven not-taken updates at an unrelated PC flush the history back to zero.
    task automatic clear_ghr();
        repeat (7) upd(32'h180, 7'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 6;
        if (pred_vld !== 1'b0)    begin errors++; $display("FAIL reset pred_vld: got %b want 0", pred_vld); end
        if (pred_taken !== 1'b0)  begin errors++; $display("FAIL reset pred_taken: got %b want 0", pred_taken); end
        if (pred_hit !== 1'b0)    begin errors++; $display("FAIL reset pred_hit: got %b want 0", pred_hit); end
        if (pred_target !== 32'h0) begin errors++; $display("FAIL reset pred_target: got %h want 0", pred_target); end
        if (pred_ghr !== 7'h0)    begin errors++; $display("FAIL reset pred_ghr: got %h want 0", pred_ghr); end
        if (mispred_cnt !== 16'h0) begin errors++; $display("FAIL reset mispred_cnt: got %h want 0", mispred_cnt); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_lookup();
        look(32'h100, 1'b0, 1'b0, 32'h104, 7'h0);
        look(32'h100, 1'b0, 1'b0, 32'h104, 7'h0);
        look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 7'h0);
        @(negedge clk);
    endtask

    task automatic test_train_hit();
        upd(32'h100, 7'h0, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 7'h0, 1'b1, 32'h200, 1'b0);
        clear_ghr();
        look(32'h100, 1'b1, 1'b1, 32'h200, 7'h0);
        @(negedge clk);
    endtask

    task automatic test_saturate();
        repeat (4) upd(32'h140, 7'h0, 1'b1, 32'h400, 1'b0);
        clear_ghr();
        look(32'h140, 1'b1, 1'b1, 32'h400, 7'h0);
        repeat (6) upd(32'h140, 7'h0, 1'b0, 32'h0, 1'b0);
        clear_ghr();
        look(32'h140, 1'b0, 1'b1, 32'h144, 7'h0);
        upd(32'h140, 7'h0, 1'b1, 32'h400, 1'b0);
        clear_ghr();
        look(32'h140, 1'b0, 1'b1, 32'h144, 7'h0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back_rbw();
        pred_req = 1'b1;
        pred_pc  = 32'h240;
        push_exp(1'b0, 1'b0, 32'h244, 7'h0);
        upd(32'h240, 7'h0, 1'b1, 32'h600, 1'b0);
        look(32'h240, 1'b0, 1'b1, 32'h244, 7'h1);
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        clear_ghr();
        repeat (3) upd(32'h180, 7'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mispred_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mispred_cnt before reset: got %0d want 3", mispred_cnt);
        end
        look(32'h100, 1'b1, 1'b1, 32'h200, 7'h0);
        pred_req = 1'b1;
        pred_pc  = 32'h100;
        #2 rst = 1'b0;
        #1;
        checks += 5;
        if (pred_vld !== 1'b0)     begin errors++; $display("FAIL async reset pred_vld: got %b want 0", pred_vld); end
        if (pred_taken !== 1'b0)   begin errors++; $display("FAIL async reset pred_taken: got %b want 0", pred_taken); end
        if (pred_hit !== 1'b0)     begin errors++; $display("FAIL async reset pred_hit: got %b want 0", pred_hit); end
        if (pred_target !== 32'h0) begin errors++; $display("FAIL async reset pred_target: got %h want 0", pred_target); end
        if (mispred_cnt !== 16'h0) begin errors++; $display("FAIL async reset mispred_cnt: got %h want 0", mispred_cnt); end
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        pred_req = 1'b0;
        look(32'h100, 1'b0, 1'b0, 32'h104, 7'h0);
        upd(32'h100, 7'h0, 1'b1, 32'h200, 1'b0);
        look(32'h104, 1'b1, 1'b0, 32'h108, 7'h1);
        @(negedge clk);
    endtask

    task automatic test_spec_ghr();
        do_reset();
        upd(32'h100, 7'h0, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 7'h1, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 7'h3, 1'b1, 32'h200, 1'b0);
        look(32'h100, 1'b1, 1'b1, 32'h200, 7'h0);
        look(32'h100, 1'b1, 1'b1, 32'h200, 7'h1);
        look(32'h100, 1'b1, 1'b1, 32'h200, 7'h3);
        pred_req = 1'b1;
        pred_pc  = 32'h100;
        push_exp(1'b0, 1'b1, 32'h104, 7'h7);
        upd(32'h100, 7'h1, 1'b0, 32'h0, 1'b1);
        look(32'h100, 1'b0, 1'b1, 32'h104, 7'h2);
        checks++;
        if (mispred_cnt !== 16'd1) begin
            errors++;
            $display("FAIL spec mispred_cnt: got %0d want 1", mispred_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_mispred_cnt();
        do_reset();
        repeat (65534) upd(32'h180, 7'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mispred_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL mispred_cnt pre-sat: got %h want fffe", mispred_cnt);
        end
        repeat (6) upd(32'h180, 7'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mispred_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL mispred_cnt saturate: got %h want ffff", mispred_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        pred_req = 1'b0;
        pred_pc = '0;
        upd_vld = 1'b0;
        upd_pc = '0;
        upd_ghr = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_mispred = 1'b0;
        test_reset();
        test_first_lookup();
`ifdef GSHARE_SPEC_GHR_EN
        test_spec_ghr();
`else
        test_train_hit();
        test_saturate();
        test_back_to_back_rbw();
        test_reset_midstream();
`endif
        test_mispred_cnt();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
